apb_controller: RTL
===================

Name: apb_controller

Overview:
- APB-side master FSM of the AHB-to-APB bridge; the other end of the AHB slave interface.
- Consumes the decoded AHB transfer (valid, address, control, slave select, write data) and runs APB SETUP/ACCESS phases toward up to NSLV peripherals.
- Drives hreadyout/hrdata/hresp back to the AHB master.
- Holds the AHB master with hreadyout=0 for the whole APB transfer, including APB pready wait states.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSLV, 3, number of APB peripherals (one-hot select width)

Ports:
- hclk  in  1  bridge clock
- hreset  in  1  synchronous reset, active-high
- valid  in  1  qualified AHB NONSEQ/SEQ transfer in address phase, in bridge range
- haddr  in  ADDR_W  AHB address, address phase
- hwrite  in  1  AHB direction, address phase
- hwdata  in  DATA_W  AHB write data, data phase (one cycle after address phase)
- temp_selx  in  NSLV  one-hot peripheral select, address phase
- prdata  in  DATA_W  read data from the selected peripheral (muxed externally)
- pready  in  1  APB ready from the selected peripheral
- pslverr  in  1  APB error; used only with APB_PSLVERR_EN
- psel  out  NSLV  APB select, one-hot
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- hreadyout  out  1  AHB ready
- hrdata  out  DATA_W  AHB read data
- hresp  out  2  AHB response: 00 OKAY, 01 ERROR

Behaviour:
- Clock hclk; reset hreset is synchronous and active-high. Sampled on posedge hclk and overrides all other logic.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hresp=00, hreadyout=1, state=IDLE.
- States and transitions:
  - IDLE: hreadyout=1. If valid && temp_selx!=0, latch haddr, hwrite and temp_selx.
    - Write: go to WWAIT.
    - Read: go to SETUP.
  - Otherwise stay in IDLE.
  - valid with temp_selx==0 is ignored.
- WWAIT (write only): hreadyout=0; capture hwdata into pwdata at the end of the cycle; go to SETUP.
- SETUP: psel=latched select, penable=0, paddr/pwrite valid, hreadyout=0; go to ACCESS unconditionally.
- ACCESS: psel held, penable=1, hreadyout=0.
  - pready=0: stay in ACCESS. No timeout.
  - pready=1: go to IDLE.
  - On a read completion, register prdata into hrdata.
- psel and penable are registered and fall to 0 on the edge leaving ACCESS.
- paddr, pwrite and pwdata hold their last values after completion.
- hrdata is updated only on read completion; writes leave it unchanged.
- hreadyout is a decode of state: 1 only in IDLE (and ERR2 when the optional feature is compiled in).
- Latency with pready=1 in the first ACCESS cycle:
  - Read: accept at T0; SETUP T1; ACCESS T2; hreadyout=1 with valid hrdata at T3.
  - Write: one cycle longer, with WWAIT at T1.
- Back-to-back: the IDLE cycle that returns hreadyout=1 also accepts the next valid, so there is no dead cycle.
- valid while not in IDLE is ignored; the master is stalled by hreadyout=0.
- Reset mid-transfer: same edge returns to IDLE, clears psel and penable, and sets hreadyout=1. The transfer is abandoned.

Optional Feature:
- Macro: APB_PSLVERR_EN.
- With the macro defined:
  - In ACCESS, pready=1 && pslverr=1 goes to ERR1 instead of IDLE; hrdata is not updated.
  - ERR1: hresp=01, hreadyout=0.
  - ERR2: hresp=01, hreadyout=1; accepts valid exactly like IDLE.
  - This is the standard AHB two-cycle ERROR response.
- Without the macro: pslverr is ignored, hresp is tied to 00, and ERR1/ERR2 do not exist.

Decomposition:
- Shared package bridge_pkg holds:
  - the state enum IDLE/WWAIT/SETUP/ACCESS/ERR1/ERR2;
  - HRESP_OKAY=2'b00 and HRESP_ERROR=2'b01;
  - the HTRANS encodings used by the bridge.
- Single module; no sub-module is natural (one FSM plus holding registers).

Test Plan:
- Read, haddr=0x8000_0010, temp_selx=001, pready=1, prdata=0xDEAD_BEEF:
  - psel=001 at T1 with penable=0; penable=1 at T2.
  - hreadyout=1 and hrdata=0xDEAD_BEEF at T3.
- Write, haddr=0x8400_0004, hwdata=0x1234_5678 at T1, pready=1:
  - WWAIT at T1; psel=010, pwrite=1, pwdata=0x1234_5678 at T2; hreadyout=1 at T4.
- Read to 0x8800_0000 with pready low for 3 ACCESS cycles:
  - penable=1 and hreadyout=0 for 4 cycles.
  - Completes on the 4th ACCESS cycle; psel=100 throughout.
- Back-to-back read then write, valid asserted in the completion IDLE cycle:
  - Second transfer accepted in that cycle; no extra idle.
  - hrdata keeps the read value after the write.
- hreset=1 in ACCESS of a write:
  - Next cycle psel=0, penable=0, hreadyout=1, hrdata=0.
  - A new read after reset completes normally.
- With APB_PSLVERR_EN, read with pready=1, pslverr=1:
  - hresp=01 for 2 cycles; hreadyout 0 then 1; hrdata unchanged.
  - Without the macro, the same stimulus gives hresp=00.

Source files
------------

// File: rtl/bridge_pkg.sv
// bridge_pkg: shared FSM states, AHB response and HTRANS encodings for the AHB-to-APB bridge
package bridge_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;
  localparam logic [1:0] HRESP_OKAY   = 2'b00;
  localparam logic [1:0] HRESP_ERROR  = 2'b01;
  localparam logic [1:0] HTRANS_IDLE  = 2'b00;
  localparam logic [1:0] HTRANS_BUSY  = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ  = 2'b10;
  localparam logic [1:0] HTRANS_SEQ   = 2'b11;
endpackage

// File: rtl/apb_controller.sv
// apb_controller: APB master FSM of the AHB-to-APB bridge; optional APB_PSLVERR_EN adds the two-cycle AHB ERROR response
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSLV-1:0]   temp_selx,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout,
  output logic [DATA_W-1:0] hrdata,
  output logic [1:0]        hresp
);
  state_t state, state_n;
  logic [NSLV-1:0] sel;
  logic accept, err;
  assign accept = (state == IDLE || state == ERR2) && valid && |temp_selx;
`ifdef APB_PSLVERR_EN
  assign err = pslverr;
`else
  logic unused_pslverr;
  assign unused_pslverr = pslverr;
  assign err = 1'b0;
`endif
  // state register
  always_ff @(posedge hclk) begin
    if (hreset) state <= IDLE;
    else state <= state_n;
  end
  // next-state logic
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE, ERR2: state_n = accept ? (hwrite ? WWAIT : SETUP) : IDLE;
      WWAIT:      state_n = SETUP;
      SETUP:      state_n = ACCESS;
      ACCESS:     state_n = !pready ? ACCESS : err ? ERR1 : IDLE;
      ERR1:       state_n = ERR2;
      default:    state_n = IDLE;
    endcase
  end
  // AHB handshake outputs decoded from state
  always_comb begin
    hreadyout = state == IDLE || state == ERR2;
`ifdef APB_PSLVERR_EN
    hresp = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    hresp = HRESP_OKAY;
`endif
  end
  // APB phase registers and held address/data; psel uses the fresh select when a read goes straight to SETUP
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sel     <= '0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      hrdata  <= '0;
    end else begin
      if (accept) begin
        sel    <= temp_selx;
        paddr  <= haddr;
        pwrite <= hwrite;
      end
      if (state == WWAIT) pwdata <= hwdata;
      if (state == ACCESS && pready && !pwrite && !err) hrdata <= prdata;
      psel    <= (state_n == SETUP || state_n == ACCESS) ? (accept ? temp_selx : sel) : '0;
      penable <= state_n == ACCESS;
    end
  end
endmodule
